ram_scan_reader: RTL and testbench

Read-side initiator for the lab's 32x8 single-port synchronous RAM (registered read data, 1-cycle latency). On a start pulse it sweeps a contiguous, wrap-around address range. Each byte is streamed out with its address over a valid/ready handshake, so hex displays, LEDs or a UART can consume RAM contents at their own pace. It owns the RAM's address port while busy; the RAM's write enable is held low by the top level while busy.

---
 rtl/ram_scan_reader.sv | 195 +++++++++++++++++++
 tb/tb_ram_scan_reader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// ram_scan_reader
//   Read-side initiator for a single-port synchronous RAM with a 1-cycle
//   registered read. A start pulse sweeps a contiguous, wrap-around address
//   range and streams every byte, tagged with its address, over a
//   valid/ready handshake.
//
//   Optional feature macro: SCAN_CHECKSUM_EN adds checksum_o, the running
//   sum (mod 2**DATA_W) of accepted bytes, cleared on an accepted start.
//
// Ports
//   clock_i      system clock, rising edge
//   reset_i      asynchronous, active-high reset
//   start_i      begin a scan (sampled only while idle)
//   base_addr_i  first address of the scan, sampled with start_i
//   count_i      number of bytes to read (0..2**ADDR_W), sampled with start_i
//   mem_addr_o   registered RAM address
//   mem_dout_i   RAM read data, valid the cycle after the RAM samples mem_addr_o
//   out_data_o   streamed byte
//   out_addr_o   address the streamed byte came from
//   out_valid_o  out_data_o/out_addr_o valid
//   out_ready_i  consumer accepts on out_valid_o & out_ready_i at a rising edge
//   busy_o       scan in progress (SCAN or FINISH)
//   done_o       one-cycle pulse, scan complete
//   checksum_o   (SCAN_CHECKSUM_EN only) sum of accepted bytes

module ram_scan_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
`ifdef SCAN_CHECKSUM_EN
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o
`else
  output logic              done_o
`endif
);

  localparam int CW    = ADDR_W + 1;
  // A read spends one cycle addressed and one cycle on mem_dout before it is
  // captured, so at one byte per cycle three bytes are outstanding between
  // issue and acceptance. The buffer holds three so the credit limit below
  // can never overrun it, whatever out_ready does.
  localparam int BUF_D = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [CW-1:0]     accepted_q, accepted_d;
  logic [CW-1:0]     outstanding;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              p1_q, p1_d;      // address on mem_addr, RAM samples next edge
  logic              p2_q;            // RAM data on mem_dout, captured next edge
  logic [ADDR_W-1:0] p2_addr_q;
  logic [DATA_W-1:0] buf_data_q [BUF_D];
  logic [ADDR_W-1:0] buf_addr_q [BUF_D];
  logic [1:0]        wr_ptr_q, rd_ptr_q, occ_q;
  logic              start_ok, issue, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_D - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    pop         = (occ_q != 2'd0) && out_ready_i;
    push        = p2_q;
    start_ok    = (state_q == S_IDLE) && start_i;
    outstanding = issued_q - accepted_q;
    // Counting a pop in the same cycle keeps full throughput with ready high.
    issue       = (state_q == S_SCAN) && (issued_q < count_q) &&
                  ((outstanding - CW'(pop)) < CW'(BUF_D));
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    mem_addr_d = mem_addr_q;
    p1_d       = 1'b0;
    if (pop) accepted_d = accepted_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          base_d     = base_addr_i;
          count_d    = count_i;
          accepted_d = '0;
          if (count_i == '0) begin
            issued_d = '0;
            state_d  = S_FINISH;
          end else begin
            // First read goes out on the start edge itself.
            mem_addr_d = base_addr_i;
            issued_d   = CW'(1);
            p1_d       = 1'b1;
            state_d    = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (issue) begin
          mem_addr_d = base_q + issued_q[ADDR_W-1:0];
          issued_d   = issued_q + CW'(1);
          p1_d       = 1'b1;
        end
        if (pop && (accepted_q == count_q - CW'(1))) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      mem_addr_q <= '0;
      p1_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      mem_addr_q <= mem_addr_d;
      p1_q       <= p1_d;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < BUF_D; i++) begin
        buf_data_q[i] <= '0;
        buf_addr_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      p2_q      <= 1'b0;
      p2_addr_q <= '0;
    end else begin
      p2_q      <= p1_q;
      p2_addr_q <= mem_addr_q;
      if (push) begin
        buf_data_q[wr_ptr_q] <= mem_dout_i;
        buf_addr_q[wr_ptr_q] <= p2_addr_q;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

`ifdef SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)       checksum_q <= '0;
    else if (start_ok) checksum_q <= '0;
    else if (pop)      checksum_q <= checksum_q + out_data_o;
  end

  assign checksum_o = checksum_q;
`endif

  assign mem_addr_o  = mem_addr_q;
  assign out_valid_o = (occ_q != 2'd0);
  assign out_data_o  = buf_data_q[rd_ptr_q];
  assign out_addr_o  = buf_addr_q[rd_ptr_q];
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FINISH);

endmodule

// File: tb/tb_ram_scan_reader.sv
module tb_ram_scan_reader;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clock, reset, start;
  logic [AW-1:0] base_addr, mem_addr, out_addr;
  logic [AW:0]   count;
  logic [DW-1:0] mem_dout, out_data;
  logic          out_valid, out_ready, busy, done;
`ifdef SCAN_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start),
    .base_addr_i(base_addr), .count_i(count),
    .mem_addr_o(mem_addr), .mem_dout_i(mem_dout),
    .out_data_o(out_data), .out_addr_o(out_addr), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .busy_o(busy),
`ifdef SCAN_CHECKSUM_EN
    .done_o(done), .checksum_o(checksum)
`else
    .done_o(done)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // RAM model: registered read, 1-cycle latency.
  logic [DW-1:0] ram [32];
  always @(posedge clock) mem_dout <= ram[mem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observations gathered by the scan driver.
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  int            obs_cyc  [$];
  int            first_valid, done_cyc, done_pulses, stable_viol, lead_viol;
  logic          busy_after, busy_at1;
  bit            timed_out;
  logic [DW-1:0] cs_at_done;

  // Reference model: expected stream from the scan rules.
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic [DW-1:0] exp_sum;

  task automatic model_scan(input int b, input int c);
    exp_addr.delete();
    exp_data.delete();
    exp_sum = '0;
    for (int i = 0; i < c; i++) begin
      int a;
      a = (b + i) % 32;
      exp_addr.push_back(AW'(a));
      exp_data.push_back(ram[a]);
      exp_sum = exp_sum + ram[a];
    end
  endtask

  // mode 0: ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random.
  task automatic do_scan(input logic [AW-1:0] b, input logic [AW:0] c, input int mode);
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int cyc, acc;
    bit prev_stall, fin;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa, d;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    first_valid = -1; done_cyc = -1; done_pulses = 0;
    stable_viol = 0; lead_viol = 0; busy_after = 1'b1; busy_at1 = 1'b0;
    cs_at_done = '0;
    @(negedge clock);
    start = 1'b1; base_addr = b; count = c;
    cyc = 0; acc = 0; prev_stall = 0; fin = 0; pd = '0; pa = '0;
    while (!fin && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 6] != 0;
        default: out_ready = $urandom_range(0, 1) != 0;
      endcase
      if (prev_stall && (!out_valid || out_data !== pd || out_addr !== pa)) stable_viol++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (cyc == 1) busy_at1 = busy;
      if (busy && cyc > 0) begin
        d = mem_addr - b - acc[AW-1:0];
        if (!(d <= 2 || d == 31)) lead_viol++;
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
`ifdef SCAN_CHECKSUM_EN
        cs_at_done = checksum;
`endif
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        fin = 1;
      end
      if (out_valid && out_ready) begin
        obs_addr.push_back(out_addr);
        obs_data.push_back(out_data);
        obs_cyc.push_back(cyc);
        acc++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pa = out_addr;
      @(negedge clock);
      start = 1'b0;
      cyc++;
    end
    timed_out = !fin;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
    repeat (2) @(negedge clock);
    vectors++;
    if ({mem_addr, out_data, out_addr, out_valid, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got mem_addr=%0h data=%0h addr=%0h valid=%b busy=%b done=%b expected all 0",
               mem_addr, out_data, out_addr, out_valid, busy, done);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    model_scan(0, 4);
    do_scan(5'd0, 6'd4, 0);
    vectors++;
    if (timed_out) begin miscompares++; $display("FAIL basic_timeout: got timeout expected done"); end
    vectors++;
    if (first_valid != 3) begin miscompares++; $display("FAIL basic_latency: got %0d expected 3", first_valid); end
    vectors++;
    if (obs_addr.size() != 4) begin miscompares++; $display("FAIL basic_count: got %0d expected 4", obs_addr.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_cyc[i] != 3 + i) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got addr=%0d data=%0h cyc=%0d expected addr=%0d data=%0h cyc=%0d",
                 i, obs_addr[i], obs_data[i], obs_cyc[i], exp_addr[i], exp_data[i], 3 + i);
      end
    end
    vectors++;
    if (done_cyc != 7 || done_pulses != 1 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got cyc=%0d pulses=%0d busy_after=%b expected 7 1 0", done_cyc, done_pulses, busy_after);
    end
  endtask

  task automatic test_wrap;
    ram[30] = 8'hAA; ram[31] = 8'hBB; ram[0] = 8'hCC;
    model_scan(30, 3);
    do_scan(5'd30, 6'd3, 0);
    vectors++;
    if (timed_out || obs_addr.size() != 3) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d bytes timeout=%b expected 3 bytes", obs_addr.size(), timed_out);
    end else for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL wrap_byte%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                 i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 32; i++) ram[i] = DW'($urandom);
    model_scan(5, 6);
    do_scan(5'd5, 6'd6, 1);
    vectors++;
    if (timed_out || obs_addr.size() != 6) begin
      miscompares++;
      $display("FAIL stall_count: got %0d bytes timeout=%b expected 6 bytes", obs_addr.size(), timed_out);
    end else for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL stall_byte%0d: got addr=%0d data=%0h expected addr=%0d data=%0h",
                 i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    vectors++;
    if (stable_viol != 0 || lead_viol != 0) begin
      miscompares++;
      $display("FAIL stall_rules: got unstable=%0d lead_violations=%0d expected 0 0", stable_viol, lead_viol);
    end
  endtask

  task automatic test_zero;
    do_scan(AW'($urandom), 6'd0, 0);
    vectors++;
    if (timed_out || first_valid != -1 || obs_addr.size() != 0) begin
      miscompares++;
      $display("FAIL zero_stream: got first_valid=%0d bytes=%0d timeout=%b expected none",
               first_valid, obs_addr.size(), timed_out);
    end
    vectors++;
    if (done_cyc != 1 || done_pulses != 1 || busy_at1 !== 1'b1 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: got done_cyc=%0d pulses=%0d busy1=%b busy2=%b expected 1 1 1 0",
               done_cyc, done_pulses, busy_at1, busy_after);
    end
  endtask

  task automatic test_random(input int iters, input bit full);
    for (int n = 0; n < iters; n++) begin
      int b, c, bad;
      for (int i = 0; i < 32; i++) ram[i] = DW'($urandom);
      b = $urandom_range(0, 31);
      c = full ? 32 : $urandom_range(1, 32);
      model_scan(b, c);
      do_scan(AW'(b), (AW+1)'(c), 2);
      vectors++;
      if (timed_out || obs_addr.size() != c) begin
        miscompares++;
        $display("FAIL rand_count: got %0d bytes timeout=%b expected %0d", obs_addr.size(), timed_out, c);
      end else begin
        bad = 0;
        for (int i = 0; i < c; i++)
          if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
        vectors++;
        if (bad != 0) begin
          miscompares++;
          $display("FAIL rand_stream: got %0d wrong bytes base=%0d count=%0d expected 0", bad, b, c);
        end
      end
      vectors++;
      if (stable_viol != 0 || lead_viol != 0 || done_pulses != 1 || busy_after !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_rules: got unstable=%0d lead=%0d pulses=%0d busy_after=%b expected 0 0 1 0",
                 stable_viol, lead_viol, done_pulses, busy_after);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 32; i++) ram[i] = DW'($urandom);
    @(negedge clock);
    start = 1'b1; base_addr = 5'd3; count = 6'd10; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre: got valid=%b busy=%b expected 1 1", out_valid, busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({mem_addr, out_data, out_addr, out_valid, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: got mem_addr=%0h data=%0h addr=%0h valid=%b busy=%b done=%b expected all 0",
               mem_addr, out_data, out_addr, out_valid, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    model_scan(0, 1);
    do_scan(5'd0, 6'd1, 0);
    vectors++;
    if (timed_out || obs_addr.size() != 1) begin
      miscompares++;
      $display("FAIL midreset_restart: got %0d bytes timeout=%b expected 1", obs_addr.size(), timed_out);
    end else begin
      vectors++;
      if (obs_addr[0] !== 5'd0 || obs_data[0] !== exp_data[0] || done_cyc != 4 || done_pulses != 1) begin
        miscompares++;
        $display("FAIL midreset_byte: got addr=%0d data=%0h done_cyc=%0d pulses=%0d expected 0 %0h 4 1",
                 obs_addr[0], obs_data[0], done_cyc, done_pulses, exp_data[0]);
      end
    end
  endtask

`ifdef SCAN_CHECKSUM_EN
  task automatic test_checksum;
    ram[0] = 8'hF0; ram[1] = 8'h20; ram[2] = 8'h05;
    model_scan(0, 3);
    do_scan(5'd0, 6'd3, 0);
    vectors++;
    if (cs_at_done !== exp_sum || checksum !== exp_sum) begin
      miscompares++;
      $display("FAIL checksum_sum: got done=%0h idle=%0h expected %0h", cs_at_done, checksum, exp_sum);
    end
    do_scan(5'd7, 6'd0, 0);
    vectors++;
    if (cs_at_done !== 8'h00) begin
      miscompares++;
      $display("FAIL checksum_clear: got %0h expected 0", cs_at_done);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_zero;
    test_random(1, 1'b1);
    test_random(5, 1'b0);
    test_reset_mid;
`ifdef SCAN_CHECKSUM_EN
    test_checksum;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
